// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller.
// Holds the FSM state encoding and watchdog width used by the top and the bench.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMcBusy,
      StFlush
   } pipe_ctrl_state_t;

   localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline and the stall controller.
// master = pipeline side (drives requests), slave = controller side.
interface pipe_stall_ctrl_if #(
   parameter int unsigned NUM_STAGES = 6,
   parameter int unsigned CNT_W      = 6,
   parameter int unsigned ADDR_W     = 32
);
   logic [NUM_STAGES-1:0] i_stallreq;
   logic                  i_mc_start;
   logic [CNT_W-1:0]      i_mc_cycles;
   logic                  i_flush;
   logic [ADDR_W-1:0]     i_flush_pc;

   logic [NUM_STAGES-1:0] o_stall;
   logic                  o_flush;
   logic [ADDR_W-1:0]     o_new_pc;
   logic                  o_mc_busy;
   logic                  o_mc_done;
   logic                  o_wdog_err;

   modport master (
      output i_stallreq, i_mc_start, i_mc_cycles, i_flush, i_flush_pc,
      input  o_stall, o_flush, o_new_pc, o_mc_busy, o_mc_done, o_wdog_err
   );

   modport slave (
      input  i_stallreq, i_mc_start, i_mc_cycles, i_flush, i_flush_pc,
      output o_stall, o_flush, o_new_pc, o_mc_busy, o_mc_done, o_wdog_err
   );
endinterface

// File: rtl/pipe_stall_ctrl_therm_mask.sv
// Highest-set-bit to thermometer mask: every bit at or below the top request is set,
// so a stalled stage also holds every stage upstream of it.
module therm_mask #(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [WIDTH-1:0] mask_o
);

   logic acc;

   always_comb begin
      mask_o = '0;
      acc    = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         acc       = acc | req_i[i];
         mask_o[i] = acc;
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: per-stage hold bits, multi-cycle op stall counter,
// flush/redirect sequencer and a sticky stall watchdog.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 6,
   parameter int unsigned MC_STAGE   = 3,
   parameter int unsigned CNT_W      = 6,
   parameter int unsigned WDOG_LIMIT = 1023,
   parameter int unsigned ADDR_W     = 32
) (
   input logic               i_clk,
   input logic               i_rst_n,
   pipe_stall_ctrl_if.slave  bus
);

   localparam logic [WDOG_W-1:0] WdogMax = WDOG_W'(WDOG_LIMIT);

   pipe_ctrl_state_t      state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_W-1:0]     new_pc_q, new_pc_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic                  wdog_err_q, wdog_err_d;

   logic                  mc_busy;
   logic [NUM_STAGES-1:0] eff_req;
   logic [NUM_STAGES-1:0] stall_mask;
   logic [NUM_STAGES-1:0] stall;

   assign mc_busy = (state_q == StMcBusy);
   assign eff_req = bus.i_stallreq | (NUM_STAGES'(mc_busy) << MC_STAGE);

   therm_mask #(
      .WIDTH (NUM_STAGES)
   ) u_therm_mask (
      .req_i  (eff_req),
      .mask_o (stall_mask)
   );

   // Holds are dropped during a flush and while reset is asserted.
   assign stall = ((state_q == StFlush) || !i_rst_n) ? '0 : stall_mask;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      new_pc_d = new_pc_q;
      if (bus.i_flush) begin
         state_d  = StFlush;
         cnt_d    = '0;
         new_pc_d = bus.i_flush_pc;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.i_mc_start && (bus.i_mc_cycles != '0)) begin
                  state_d = StMcBusy;
                  cnt_d   = bus.i_mc_cycles - CNT_W'(1);
               end
            end
            StMcBusy: begin
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Saturating count of consecutive stalled cycles.
   always_comb begin
      wdog_d = wdog_q;
      if (stall == '0) begin
         wdog_d = '0;
      end else if (wdog_q != WdogMax) begin
         wdog_d = wdog_q + WDOG_W'(1);
      end
      wdog_err_d = wdog_err_q | (wdog_d == WdogMax);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         new_pc_q   <= '0;
         wdog_q     <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         new_pc_q   <= new_pc_d;
         wdog_q     <= wdog_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign bus.o_stall    = stall;
   assign bus.o_flush    = (state_q == StFlush);
   assign bus.o_new_pc   = new_pc_q;
   assign bus.o_mc_busy  = mc_busy;
   assign bus.o_mc_done  = mc_busy && (cnt_q == '0);
   assign bus.o_wdog_err = wdog_err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: driver pushes expected per-cycle outputs from a
// remaining-cycles reference model; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

   localparam int NS    = 6;
   localparam int MC    = 3;
   localparam int CW    = 6;
   localparam int AW    = 32;
   localparam int LIMIT = 8;

   typedef struct {
      logic [NS-1:0] stall;
      logic          flush;
      logic [AW-1:0] pc;
      logic          busy;
      logic          done;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW), .ADDR_W(AW)) bus ();

   pipe_stall_ctrl #(
      .NUM_STAGES (NS),
      .MC_STAGE   (MC),
      .CNT_W      (CW),
      .WDOG_LIMIT (LIMIT),
      .ADDR_W     (AW)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model: remaining busy cycles, flush-in-progress flag, watchdog run length.
   int          mc_left;
   bit          flushing;
   logic [31:0] pc_m;
   int          wd;
   bit          err_m;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc_left  = 0;
      flushing = 0;
      pc_m     = '0;
      wd       = 0;
      err_m    = 0;
   endtask

   task automatic drive(input logic [NS-1:0] req, input bit start, input int cyc,
                        input bit fl, input logic [31:0] fpc);
      exp_t e;
      int   hs;
      @(posedge clk);
      #1;
      bus.i_stallreq  = req;
      bus.i_mc_start  = start;
      bus.i_mc_cycles = CW'(cyc);
      bus.i_flush     = fl;
      bus.i_flush_pc  = fpc;

      e.busy  = (mc_left > 0);
      e.done  = (mc_left == 1);
      e.flush = flushing;
      e.pc    = pc_m;
      e.err   = err_m;
      hs = -1;
      for (int i = 0; i < NS; i++) if (req[i] || (e.busy && i == MC)) hs = i;
      e.stall = '0;
      if (!flushing) for (int i = 0; i <= hs; i++) e.stall[i] = 1'b1;
      q.push_back(e);

      if (e.stall != '0) wd = (wd < LIMIT) ? wd + 1 : LIMIT;
      else wd = 0;
      if (wd == LIMIT) err_m = 1;

      if (fl) begin
         flushing = 1;
         pc_m     = fpc;
         mc_left  = 0;
      end else if (flushing) begin
         flushing = 0;
      end else if (mc_left > 0) begin
         mc_left--;
      end else if (start && cyc != 0) begin
         mc_left = cyc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, 0, 0, 0, '0);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("o_stall", 32'(bus.o_stall), 32'(e.stall));
         chk("o_flush", 32'(bus.o_flush), 32'(e.flush));
         if (e.flush) chk("o_new_pc", bus.o_new_pc, e.pc);
         chk("o_mc_busy", 32'(bus.o_mc_busy), 32'(e.busy));
         chk("o_mc_done", 32'(bus.o_mc_done), 32'(e.done));
         chk("o_wdog_err", 32'(bus.o_wdog_err), 32'(e.err));
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, " o_stall"}, 32'(bus.o_stall), 32'd0);
      chk({tag, " o_flush"}, 32'(bus.o_flush), 32'd0);
      chk({tag, " o_new_pc"}, bus.o_new_pc, 32'd0);
      chk({tag, " o_mc_busy"}, 32'(bus.o_mc_busy), 32'd0);
      chk({tag, " o_mc_done"}, 32'(bus.o_mc_done), 32'd0);
      chk({tag, " o_wdog_err"}, 32'(bus.o_wdog_err), 32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.i_stallreq  = '1;
      bus.i_mc_start  = 1'b0;
      bus.i_mc_cycles = '0;
      bus.i_flush     = 1'b0;
      bus.i_flush_pc  = '0;
      model_reset();
      #2;
      check_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Stall mapping
      drive(6'b000100, 0, 0, 0, '0);
      drive(6'b001100, 0, 0, 0, '0);
      idle(1);
      drive(6'b100001, 0, 0, 0, '0);
      idle(1);

      // Multi-cycle op of 4
      drive('0, 1, 4, 0, '0);
      drive('0, 1, 2, 0, '0);
      idle(5);

      // Flush during cycle 2 of a 10-cycle op
      drive('0, 1, 10, 0, '0);
      idle(1);
      drive('0, 0, 0, 1, 32'h0000_0180);
      drive(6'b111111, 0, 0, 0, '0);
      drive(6'b111111, 0, 0, 0, '0);
      idle(2);

      // Flush together with start, zero-length start, back-to-back flush
      drive('0, 1, 5, 1, 32'h0000_0044);
      drive('0, 0, 0, 1, 32'h0000_0088);
      idle(2);
      drive('0, 1, 0, 0, '0);
      idle(2);

      // Watchdog: 7-cycle bursts never trip, holding stage 1 does
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 7; i++) drive(6'b000010, 0, 0, 0, '0);
         idle(1);
      end
      for (int i = 0; i < 10; i++) drive(6'b000010, 0, 0, 0, '0);
      idle(3);

      // Async reset mid multi-cycle op
      drive('0, 1, 10, 0, '0);
      idle(2);
      @(negedge clk);
      #1;
      bus.i_stallreq = '1;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(2);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         logic [NS-1:0] r;
         r = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
         drive(r, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 6)),
               ($urandom_range(0, 14) == 0), $urandom);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Parametrised successor of the 6-stage pause controller; generalised to NUM_STAGES pipeline stages with one stall-request line per stage.
- Adds a built-in multi-cycle stall counter (for DIV/MUL-style ops).
- Adds an exception/flush sequencer that cancels stalls and redirects PC.
- Adds a stall watchdog.
- Sits beside the pipeline registers; drives every stage's hold bit plus the global flush.

Parameters:
- NUM_STAGES, 6, number of stall bits; bit 0 = PC, bit k = pipeline register after stage k.
- MC_STAGE, 3, stage index that issues multi-cycle ops (EX).
- CNT_W, 6, width of the multi-cycle cycle count.
- WDOG_LIMIT, 1023, max consecutive stalled cycles before error; range 1..2^16-1.
- ADDR_W, 32, PC width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stallreq  in  NUM_STAGES  per-stage stall request; bit s = stage s requests stall (`STOP = 1)
- i_mc_start  in  1  pulse: start multi-cycle op in MC_STAGE
- i_mc_cycles  in  CNT_W  number of stall cycles for the op (0 = no stall)
- i_flush  in  1  exception/flush request
- i_flush_pc  in  ADDR_W  redirect target, sampled with i_flush
- o_stall  out  NUM_STAGES  hold bit per stage
- o_flush  out  1  one-cycle flush of all pipeline registers
- o_new_pc  out  ADDR_W  redirect PC, valid while o_flush = 1
- o_mc_busy  out  1  multi-cycle counter running
- o_mc_done  out  1  one-cycle pulse on the last stall cycle of a multi-cycle op
- o_wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, i_rst_n = 0):
  - state = IDLE, counters cleared.
  - o_stall, o_flush, o_mc_busy, o_mc_done, o_wdog_err = 0; o_new_pc = 0.
  - o_stall is forced to 0 while reset is asserted.
- Stall mapping (combinational):
  - eff_req = i_stallreq OR (o_mc_busy << MC_STAGE).
  - s = highest set bit of eff_req → o_stall[s:0] = 1, all higher bits = 0.
  - No request → o_stall = 0.
  - NUM_STAGES = 6: stage-2 request → 6'b000111; stage-3 request → 6'b001111.
- FSM states: IDLE, MC_BUSY, FLUSH.
  - IDLE → MC_BUSY: i_mc_start = 1 and i_mc_cycles ≠ 0. Load cnt = i_mc_cycles - 1 on the next edge.
  - i_mc_start with i_mc_cycles = 0: ignored; no o_mc_done.
  - MC_BUSY:
    - o_mc_busy = 1; cnt decrements each cycle.
    - On the cycle with cnt = 0: o_mc_done = 1, then next state = IDLE.
    - Total busy cycles = i_mc_cycles.
    - i_mc_start while busy is ignored.
  - Any state → FLUSH: on i_flush = 1. Flush has priority over everything.
    - Takes effect on the next edge: o_flush = 1 and o_new_pc = i_flush_pc captured that edge.
    - Counter cleared; o_mc_busy = 0; o_mc_done not pulsed.
  - FLUSH lasts exactly 1 cycle:
    - o_stall forced to 0 regardless of i_stallreq.
    - Next state = IDLE.
    - i_flush again during FLUSH → stays in FLUSH and re-captures PC.
- Simultaneous i_flush and i_mc_start: flush wins; mc start dropped.
- o_mc_done and o_flush are mutually exclusive.
- Watchdog:
  - 16-bit counter increments each cycle o_stall ≠ 0 and clears when o_stall = 0.
  - When count reaches WDOG_LIMIT, o_wdog_err sets and holds until reset.
  - Counter saturates at WDOG_LIMIT.
- Reset mid-operation (MC_BUSY or FLUSH): immediately returns to IDLE; all outputs 0.
- Outputs o_flush, o_new_pc, o_mc_busy, o_mc_done, o_wdog_err are registered or state-decoded. o_stall is combinational from inputs and state.

Decomposition:
- Shared package (pipe_ctrl_pkg): typedef enum {IDLE, MC_BUSY, FLUSH} pipe_ctrl_state_t; `STOP/`NOSTOP remain in defines.svh.
- One sub-module, therm_mask: highest-set-bit → thermometer mask, parametrised by width. Used for the o_stall mapping.

Test Plan:
1. Reset, then i_stallreq = 6'b000100 → o_stall = 6'b000111; then 6'b001100 → 6'b001111; then 0 → 0, same cycle.
2. i_mc_start with i_mc_cycles = 4 → o_mc_busy = 1 for 4 cycles and o_stall = 6'b001111 throughout; o_mc_done pulses on the 4th cycle; back to IDLE after.
3. i_flush with i_flush_pc = 32'h0000_0180 during cycle 2 of a 10-cycle mc op → next cycle o_flush = 1, o_new_pc = 32'h180, o_stall = 0 (even with i_stallreq = 6'b111111); no o_mc_done; then IDLE.
4. i_flush and i_mc_start in the same cycle → flush only; o_mc_busy stays 0; i_mc_cycles = 0 start → no busy, no done.
5. WDOG_LIMIT = 8, hold i_stallreq[1] = 1 → o_wdog_err rises on the 8th consecutive stalled cycle and stays 1 after the request drops; 7-cycle stall bursts never set it.
6. Assert i_rst_n = 0 asynchronously mid-MC_BUSY → all outputs 0 without waiting for a clock edge; after release, o_mc_busy = 0.
